// File: rtl/i2s_tx_sequencer.sv
// I2S transmitter: one frame counter generates MCLK/SCLK/LRCK and times sample loads,
// with a one-entry holding register in front of the active L/R shift source.
module i2s_tx_sequencer #(
  parameter int MCLK_HALF  = 4,
  parameter int SCLK_RATIO = 4,
  parameter int LRCK_RATIO = 256,
  parameter int SAMPLE_W   = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                mclk,
  output logic                sclk,
  output logic                lrck,
  output logic                sdata,
  output logic                underrun
);

  localparam int FW       = $clog2(2 * MCLK_HALF * LRCK_RATIO);
  localparam int MCLK_BIT = $clog2(MCLK_HALF);
  localparam int SCLK_BIT = $clog2(2 * MCLK_HALF * SCLK_RATIO) - 1;
  localparam int SLOT_LO  = SCLK_BIT + 1;
  localparam int SLOT_W   = FW - 1 - SLOT_LO;
  localparam logic [FW-1:0] FRAME_LAST = '1;

  logic [FW-1:0]       fcnt_q, fcnt_d;
  logic                hold_full_q, hold_full_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [SAMPLE_W-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
  logic                mclk_q, mclk_d, sclk_q, sclk_d, lrck_q, lrck_d;
  logic                sdata_q, sdata_d, underrun_q, underrun_d;

  logic                load, xfer, sdata_bit;
  logic [SLOT_W-1:0]   slot_b;
  logic [SAMPLE_W-1:0] chan;

  assign load    = en && (fcnt_q == FRAME_LAST);
  assign s_ready = !hold_full_q || load;
  assign xfer    = s_valid && s_ready;

  // Slot 0 is the one-SCLK I2S delay; slots past SAMPLE_W are zero padding.
  always_comb begin
    slot_b    = fcnt_q[FW-2:SLOT_LO];
    chan      = fcnt_q[FW-1] ? act_r_q : act_l_q;
    sdata_bit = 1'b0;
    for (int i = 1; i <= SAMPLE_W; i++) begin
      if (int'(slot_b) == i) sdata_bit = chan[SAMPLE_W-i];
    end
  end

  always_comb begin
    fcnt_d      = fcnt_q;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    act_l_d     = act_l_q;
    act_r_d     = act_r_q;

    if (!en) begin
      fcnt_d  = '0;
      act_l_d = '0;
      act_r_d = '0;
    end else begin
      fcnt_d = fcnt_q + 1'b1;
    end

    if (load) begin
      if (hold_full_q) begin
        act_l_d     = hold_l_q;
        act_r_d     = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
        act_l_d = '0;
        act_r_d = '0;
      end
    end

    // A same-cycle transfer refills the slot the load just emptied.
    if (xfer) begin
      hold_l_d    = s_left;
      hold_r_d    = s_right;
      hold_full_d = 1'b1;
    end

    mclk_d     = en && fcnt_q[MCLK_BIT];
    sclk_d     = en && fcnt_q[SCLK_BIT];
    lrck_d     = en && fcnt_q[FW-1];
    sdata_d    = en && sdata_bit;
    underrun_d = load && !hold_full_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q      <= '0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      act_l_q     <= '0;
      act_r_q     <= '0;
      mclk_q      <= 1'b0;
      sclk_q      <= 1'b0;
      lrck_q      <= 1'b0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      fcnt_q      <= fcnt_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      act_l_q     <= act_l_d;
      act_r_q     <= act_r_d;
      mclk_q      <= mclk_d;
      sclk_q      <= sclk_d;
      lrck_q      <= lrck_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
    end
  end

  assign mclk     = mclk_q;
  assign sclk     = sclk_q;
  assign lrck     = lrck_q;
  assign sdata    = sdata_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Bench for i2s_tx_sequencer: timing table, directed frame sequences, and random
// streaming checked every cycle against an arithmetic frame model.
module tb_i2s_tx_sequencer;

  localparam int FRAME = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] s_left = '0;
  logic [23:0] s_right = '0;
  logic        mclk, sclk, lrck, sdata, underrun;

  always #5 clk = ~clk;

  i2s_tx_sequencer dut (
    .clk(clk), .rst(rst), .en(en),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .mclk(mclk), .sclk(sclk), .lrck(lrck), .sdata(sdata), .underrun(underrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: frame position as an integer, pending pairs as a queue.
  int          m_f = 0;
  logic [23:0] m_al = '0, m_ar = '0;
  logic [47:0] m_hq[$];
  logic [4:0]  m_exp = '0;   // {mclk, sclk, lrck, sdata, underrun}
  bit          last_xfer = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ld, rdy;
    last_xfer = 0;
    if (rst) begin
      m_f = 0; m_al = '0; m_ar = '0; m_exp = '0;
      m_hq.delete();
      return;
    end
    m_exp = '0;
    if (en) begin
      int          b;
      bit          right;
      logic [23:0] ch;
      b     = (m_f % (FRAME / 2)) / 32;
      right = (m_f >= FRAME / 2);
      ch    = right ? m_ar : m_al;
      m_exp[4] = ((m_f / 4) % 2) == 1;
      m_exp[3] = ((m_f / 16) % 2) == 1;
      m_exp[2] = right;
      if (b >= 1 && b <= 24) m_exp[1] = ch[24-b];
    end
    ld  = en && (m_f == FRAME - 1);
    rdy = (m_hq.size() == 0) || ld;
    last_xfer = s_valid && rdy;
    if (ld) begin
      if (m_hq.size() > 0) {m_al, m_ar} = m_hq.pop_front();
      else begin m_al = '0; m_ar = '0; m_exp[0] = 1'b1; end
    end
    if (last_xfer) m_hq.push_back({s_left, s_right});
    if (!en) begin m_f = 0; m_al = '0; m_ar = '0; end
    else m_f = (m_f + 1) % FRAME;
  endtask

  task automatic tick();
    bit exp_rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    exp_rdy = (m_hq.size() == 0) || (en && m_f == FRAME - 1);
    chk("outputs", 64'({mclk, sclk, lrck, sdata, underrun}), 64'(m_exp));
    chk("s_ready", 64'(s_ready), 64'(exp_rdy));
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; s_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    s_left = l; s_right = r; s_valid = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (last_xfer) break;
    end
    chk("push_accepted", 64'(last_xfer), 64'd1);
    s_valid = 1'b0;
  endtask

  task automatic run_to(input int n);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_f == n) break;
      tick();
    end
  endtask

  // One full frame of outputs; slot words assembled from sdata at sclk rising edges.
  task automatic collect_frame(output logic [31:0] lw, output logic [31:0] rw,
                               output int urc, output int ones);
    logic prev;
    int   idx;
    prev = sclk; idx = 0; lw = '0; rw = '0; urc = 0; ones = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (sclk && !prev) begin
        if (idx < 32) lw = {lw[30:0], sdata};
        else if (idx < 64) rw = {rw[30:0], sdata};
        idx++;
      end
      prev = sclk;
      urc += int'(underrun);
      ones += int'(sdata);
    end
    chk("sclk_rises_per_frame", 64'(idx), 64'd64);
  endtask

  function automatic logic [31:0] slot_word(input logic [23:0] x);
    return {1'b0, x, 7'b0};
  endfunction

  typedef struct {
    int         k;      // clk edges since en rose
    logic       vld;    // s_valid held during the run
    logic [4:0] exp;    // {mclk, sclk, lrck, sdata, underrun}
  } vec_t;

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] lw, rw;
    int urc, ones;

    vecs[0] = '{k: 1,    vld: 1'b0, exp: 5'b00000};
    vecs[1] = '{k: 5,    vld: 1'b0, exp: 5'b10000};
    vecs[2] = '{k: 9,    vld: 1'b0, exp: 5'b00000};
    vecs[3] = '{k: 17,   vld: 1'b0, exp: 5'b01000};
    vecs[4] = '{k: 21,   vld: 1'b0, exp: 5'b11000};
    vecs[5] = '{k: 1024, vld: 1'b0, exp: 5'b11000};
    vecs[6] = '{k: 1025, vld: 1'b0, exp: 5'b00100};
    vecs[7] = '{k: 2048, vld: 1'b0, exp: 5'b11101};
    vecs[8] = '{k: 2049, vld: 1'b0, exp: 5'b00000};

    // Reset state
    do_reset();
    chk("reset_outputs", 64'({mclk, sclk, lrck, sdata, underrun}), 64'd0);
    chk("reset_ready", 64'(s_ready), 64'd1);

    // Timebase with no samples
    begin
      int vi = 0, mrise = 0, srise = 0, lrise = 0, m1 = 0, m2 = 0, s1 = 0, s2 = 0, l1 = 0;
      logic pm = 1'b0, ps = 1'b0, pl = 1'b0;
      en = 1'b1;
      for (int k = 1; k <= FRAME + 1; k++) begin
        s_valid = vecs[vi].vld;
        tick();
        if (vi < 9 && vecs[vi].k == k) begin
          chk($sformatf("timing_k%0d", k), 64'({mclk, sclk, lrck, sdata, underrun}), 64'(vecs[vi].exp));
          vi++;
        end
        if (k <= FRAME) begin
          if (mclk && !pm) begin mrise++; if (m1 == 0) m1 = k; else if (m2 == 0) m2 = k; end
          if (sclk && !ps) begin srise++; if (s1 == 0) s1 = k; else if (s2 == 0) s2 = k; end
          if (lrck && !pl) begin lrise++; if (l1 == 0) l1 = k; end
        end
        pm = mclk; ps = sclk; pl = lrck;
      end
      chk("mclk_period", 64'(m2 - m1), 64'd8);
      chk("sclk_period", 64'(s2 - s1), 64'd32);
      chk("mclk_rises", 64'(mrise), 64'd256);
      chk("sclk_rises", 64'(srise), 64'd64);
      chk("lrck_rises", 64'(lrise), 64'd1);
      chk("lrck_first_high", 64'(l1), 64'd1025);
    end

    // Data format
    do_reset();
    en = 1'b1;
    push(24'hA5A5A5, 24'h3C3C3C);
    run_to(0);
    collect_frame(lw, rw, urc, ones);
    chk("fmt_left", 64'(lw), 64'(slot_word(24'hA5A5A5)));
    chk("fmt_right", 64'(rw), 64'(slot_word(24'h3C3C3C)));
    chk("fmt_left_const", 64'(lw), 64'h52D2D280);

    // Backpressure: P2 waits for the load cycle
    do_reset();
    en = 1'b1;
    push(24'h123456, 24'h654321);
    begin
      int waited = 0, ready_hi = 0;
      s_left = 24'hFEDCBA; s_right = 24'h0F0F0F; s_valid = 1'b1;
      for (int i = 0; i < 3 * FRAME; i++) begin
        if (s_ready && m_f != FRAME - 1) ready_hi++;
        tick();
        waited++;
        if (last_xfer) break;
      end
      s_valid = 1'b0;
      chk("bp_wait_cycles", 64'(waited), 64'd2047);
      chk("bp_ready_early", 64'(ready_hi), 64'd0);
    end
    collect_frame(lw, rw, urc, ones);
    chk("bp_p1_left", 64'(lw), 64'(slot_word(24'h123456)));
    chk("bp_p1_right", 64'(rw), 64'(slot_word(24'h654321)));
    chk("bp_p1_underrun", 64'(urc), 64'd0);
    collect_frame(lw, rw, urc, ones);
    chk("bp_p2_left", 64'(lw), 64'(slot_word(24'hFEDCBA)));
    chk("bp_p2_right", 64'(rw), 64'(slot_word(24'h0F0F0F)));
    // The load ending this frame is the first starved one.
    chk("bp_p2_underrun", 64'(urc), 64'd1);

    // Underrun after the stream stops
    do_reset();
    en = 1'b1;
    push(24'h111111, 24'h222222);
    push(24'h333333, 24'h444444);
    push(24'h555555, 24'h666666);
    collect_frame(lw, rw, urc, ones);
    chk("ur_b_left", 64'(lw), 64'(slot_word(24'h333333)));
    chk("ur_b_underrun", 64'(urc), 64'd0);
    collect_frame(lw, rw, urc, ones);
    chk("ur_c_right", 64'(rw), 64'(slot_word(24'h666666)));
    chk("ur_c_underrun", 64'(urc), 64'd1);
    collect_frame(lw, rw, urc, ones);
    chk("ur_starved_ones", 64'(ones), 64'd0);
    chk("ur_starved_pulses", 64'(urc), 64'd1);
    collect_frame(lw, rw, urc, ones);
    chk("ur_starved2_pulses", 64'(urc), 64'd1);

    // en dropped mid-frame keeps the held pair
    do_reset();
    en = 1'b1;
    push(24'h800001, 24'h7FFFFE);
    run_to(700);
    en = 1'b0;
    tick();
    chk("endrop_outputs", 64'({mclk, sclk, lrck, sdata, underrun}), 64'd0);
    repeat (5) tick();
    chk("endrop_hold_full", 64'(s_ready), 64'd0);
    en = 1'b1;
    collect_frame(lw, rw, urc, ones);
    chk("endrop_zero_frame", 64'({lw, rw}), 64'd0);
    chk("endrop_zero_underrun", 64'(urc), 64'd0);
    collect_frame(lw, rw, urc, ones);
    chk("endrop_left", 64'(lw), 64'(slot_word(24'h800001)));
    chk("endrop_right", 64'(rw), 64'(slot_word(24'h7FFFFE)));

    // Reset mid-frame discards the held pair
    do_reset();
    en = 1'b1;
    push(24'hDEADBE, 24'hEFCAFE);
    run_to(300);
    rst = 1'b1;
    tick();
    chk("rst_mid_outputs", 64'({mclk, sclk, lrck, sdata, underrun}), 64'd0);
    chk("rst_mid_ready", 64'(s_ready), 64'd1);
    rst = 1'b0;
    collect_frame(lw, rw, urc, ones);
    chk("rst_mid_frame1", 64'({lw, rw}), 64'd0);
    chk("rst_mid_underrun", 64'(urc), 64'd1);
    collect_frame(lw, rw, urc, ones);
    chk("rst_mid_frame2_ones", 64'(ones), 64'd0);

    // Random streaming with occasional enable drops
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (!s_valid || last_xfer) begin
        s_valid = 1'b0;
        if ($urandom_range(0, 2999) < 3) begin
          s_valid = 1'b1;
          s_left  = 24'($urandom);
          s_right = 24'($urandom);
        end
      end
      if (en && $urandom_range(0, 2999) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      tick();
    end
    s_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
